alu_seq_ctrl: RTL

- Multi-cycle control sequencer that drives the custom processor's 16-bit, 2-opcode-bit ALU: it sends operands A/B and the opcode, and consumes the combinational result.
- Fetches 16-bit instructions over a request/valid memory handshake and decodes them.
- Holds a 4-entry register file and writes results back.
- Sits between instruction memory and the ALU; it is the initiator side of the ALU interface.

---
 rtl/alu_seq_ctrl_if.sv | 28 ++
 rtl/alu_seq_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Bus bundle between the sequencer and its two neighbours: the
// instruction memory (request/valid fetch handshake) and the ALU
// (operands and opcode out, combinational result back).
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int PC_W  = 8
);
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [15:0]      imem_rdata;
  logic             imem_valid;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_result;

  // Sequencer side: initiates fetches and ALU operations
  modport master (
    output imem_req, imem_addr, alu_a, alu_b, alu_op,
    input  imem_rdata, imem_valid, alu_result
  );

  // Memory/ALU side: answers fetches and computes results
  modport slave (
    input  imem_req, imem_addr, alu_a, alu_b, alu_op,
    output imem_rdata, imem_valid, alu_result
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, decodes
// them, drives the external ALU and writes results back into a 4-entry
// register file. One instruction is fully retired before the next
// fetch starts, so there are no register hazards to resolve.
module alu_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  alu_seq_ctrl_if.master    bus,
  input  logic [1:0]        dbg_sel,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LI   = 2'b01;
  localparam logic [1:0] CLS_HALT = 2'b10;
  localparam logic [1:0] CLS_NOP  = 2'b11;

  state_t           state;
  state_t           next_state;
  logic [PC_W-1:0]  pc;
  logic [15:0]      instr;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       alu_op_q;

  logic [1:0] cls;
  logic [1:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic [7:0] imm8;

  assign cls  = instr[15:14];
  assign op   = instr[13:12];
  assign rd   = instr[11:10];
  assign rs1  = instr[9:8];
  assign rs2  = instr[7:6];
  assign imm8 = instr[7:0];

  // Fetch request is decoded from state so it drops the moment reset hits
  assign bus.imem_req  = (state == FETCH);
  assign bus.imem_addr = pc;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;

  assign busy     = (state == FETCH) || (state == DECODE) ||
                    (state == EXEC)  || (state == WB);
  assign halted   = (state == HALT);
  assign dbg_data = regs[dbg_sel];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; HALT is only left through reset
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = FETCH;
      FETCH:  if (bus.imem_valid) next_state = DECODE;
      DECODE: begin
        case (cls)
          CLS_ALU:  next_state = EXEC;
          CLS_LI:   next_state = WB;
          CLS_HALT: next_state = HALT;
          CLS_NOP:  next_state = WB;
          default:  next_state = WB;
        endcase
      end
      EXEC:    next_state = WB;
      WB:      next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: instruction latch, operand launch, result capture, write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      instr       <= '0;
      result      <= '0;
      retired_cnt <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (bus.imem_valid) begin
            instr <= bus.imem_rdata;
          end
        end
        DECODE: begin
          if (cls == CLS_ALU) begin
            alu_a_q  <= regs[rs1];
            alu_b_q  <= regs[rs2];
            alu_op_q <= op;
          end
        end
        EXEC: begin
          result <= bus.alu_result;
        end
        WB: begin
          if (cls == CLS_ALU) begin
            regs[rd] <= result;
          end else if (cls == CLS_LI) begin
            regs[rd] <= WIDTH'(imm8);
          end
          pc <= pc + PC_W'(1);
          if (retired_cnt != {CNT_W{1'b1}}) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
